fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage for a phase-sequenced controller.
//
// A fetch is issued on the IF strobe and then waits for the memory
// handshake. The PC is advanced or redirected on the WB strobe.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   reset          synchronous, active-high
//   if_stb         IF phase strobe; issues a fetch when idle
//   wb_stb         WB phase strobe; advances or redirects pc when idle
//   branch_taken   selects branch_target as the next pc at WB
//   branch_target  redirect address
//   imem_req       instruction memory request
//   imem_addr      fetch address (zero when no request)
//   imem_ack       memory response valid (ignored without imem_req)
//   imem_rdata     fetched word, valid with imem_ack
//   pc             current pc
//   npc            pc + 4, combinational
//   ir             instruction register
//   ir_valid       ir holds the word fetched for the current pc
//   fetch_busy     fetch outstanding
//   fetch_err      sticky protocol error flag (cleared only by reset)
//   misalign       misaligned-fetch flag
//
// Build option FETCH_ALIGN_CHECK_EN:
//   defined   -- if_stb with pc[1:0] != 0 issues no request, loads NOP_WORD
//                into ir and raises misalign until the next aligned if_stb.
//   undefined -- imem_addr[1:0] is forced to zero and misalign is tied low.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no fetch outstanding; if_stb may issue one
// WAIT  | request held on imem_req until imem_ack

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_stb,
  input  logic        wb_stb,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic        misalign
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] ir_q;
  logic        ir_valid_q;
  logic        fetch_err_q;
  logic        aligned;
  logic [31:0] fetch_addr;
  logic        issue;
  logic        done;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;
  assign aligned    = (pc_q[1:0] == 2'b00);
  assign fetch_addr = pc_q;
  assign misalign   = misalign_q;
`else
  assign aligned    = 1'b1;
  assign fetch_addr = {pc_q[31:2], 2'b00};
  assign misalign   = 1'b0;
`endif

  // Reset gates the request in the same cycle so a fetch is never
  // presented while the unit is being reset.
  assign issue    = !reset && (state == ST_IDLE) && if_stb && aligned;
  assign imem_req = issue || (!reset && (state == ST_WAIT));
  // In WAIT the address comes from the issue-time copy: a WB in the issue
  // cycle may already have moved pc.
  assign imem_addr = !imem_req ? 32'h0000_0000 :
                     (state == ST_WAIT) ? addr_q : fetch_addr;
  assign done      = imem_req && imem_ack;

  assign pc         = pc_q;
  assign npc        = pc_q + 32'd4;
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_busy = (state == ST_WAIT);
  assign fetch_err  = fetch_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= 32'h0000_0000;
      ir_q        <= NOP_WORD;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (issue && !imem_ack) state <= ST_WAIT;
        ST_WAIT: if (imem_ack) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (issue) addr_q <= fetch_addr;

      if (done) begin
        ir_q       <= imem_rdata;
        ir_valid_q <= 1'b1;
      end else if ((state == ST_IDLE) && if_stb) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (aligned) begin
          ir_valid_q <= 1'b0;
        end else begin
          ir_q       <= NOP_WORD;
          ir_valid_q <= 1'b1;
        end
`else
        ir_valid_q <= 1'b0;
`endif
      end

`ifdef FETCH_ALIGN_CHECK_EN
      if ((state == ST_IDLE) && if_stb) misalign_q <= !aligned;
`endif

      if ((state == ST_WAIT) && (if_stb || wb_stb)) fetch_err_q <= 1'b1;

      if (wb_stb && (state == ST_IDLE))
        pc_q <= branch_taken ? branch_target : npc;
    end
  end

endmodule
